pipelined_add_sub: RTL and testbench

//  Parametrised, pipelined two's-complement adder/subtractor with valid/ready flow control.
//  - Splits the BUS_WIDTH operation into STAGES segments.
//  - Each segment adds in its own clock cycle; the segment carry is registered between stages.
//  - Produces sum, carry-out, signed overflow and zero flags.
//  - Optional signed saturation.
//  - Sits between the operand register file and the result bus.
//  - Successor to the combinational ripple adder for wide or high-frequency datapaths.

---
 rtl/pipelined_add_sub_pkg.sv | 29 ++
 rtl/pipelined_add_sub_add_segment.sv | 42 ++++
 rtl/pipelined_add_sub.sv | 145 ++++++++++++++
 tb/tb_pipelined_add_sub.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_add_sub_pkg.sv
// Shared sizing helpers and saturation constants for the pipelined adder/subtractor.
package pipelined_add_sub_pkg;

  localparam int unsigned MAX_W = 1024;

  function automatic int unsigned seg_w(input int unsigned bus_width, input int unsigned stages);
    return bus_width / stages;
  endfunction

  // Largest positive two's-complement value of width w, right-aligned in MAX_W bits.
  function automatic logic [MAX_W-1:0] max_pos(input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i + 1 < w) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] max_neg(input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i + 1 == w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipelined_add_sub_add_segment.sv
// Combinational ripple segment {cout,sum} = a + b + cin built from full adders,
// also exposing the carry into the segment MSB for signed-overflow detection.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module add_segment
  import pipelined_add_sub_pkg::*;
#(
  parameter int unsigned SEG_W = 8
) (
  input  logic [SEG_W-1:0] i_a,
  input  logic [SEG_W-1:0] i_b,
  input  logic             i_cin,
  output logic [SEG_W-1:0] o_sum,
  output logic             o_cout,
  output logic             o_c_msb
);
  logic [SEG_W:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < SEG_W; i++) begin : g_bit
    full_adder u_fa (
      .i_a (i_a[i]),
      .i_b (i_b[i]),
      .i_c (w_c[i]),
      .o_s (o_sum[i]),
      .o_c (w_c[i+1])
    );
  end

  assign o_cout  = w_c[SEG_W];
  assign o_c_msb = w_c[SEG_W-1];
endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: one SEG_W-bit segment per stage,
// registered inter-segment carry, valid/ready flow control with a global advance enable.
module pipelined_add_sub
  import pipelined_add_sub_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned STAGES    = 4,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 add_sub_b,
  input  logic                 cin,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 cout,
  output logic                 ovf,
  output logic                 zero
);
  localparam int unsigned SEG_W = seg_w(BUS_WIDTH, STAGES);
  localparam logic [BUS_WIDTH-1:0] SAT_POS = BUS_WIDTH'(max_pos(BUS_WIDTH));
  localparam logic [BUS_WIDTH-1:0] SAT_NEG = BUS_WIDTH'(max_neg(BUS_WIDTH));

  if (BUS_WIDTH % STAGES != 0) begin : g_bad_cfg
    $error("pipelined_add_sub: BUS_WIDTH must be a multiple of STAGES");
  end

  logic                 w_adv;
  logic                 r_v   [STAGES];
  logic                 r_sub [STAGES];
  logic                 r_c   [STAGES];
  logic [BUS_WIDTH-1:0] r_a   [STAGES];
  logic [BUS_WIDTH-1:0] r_b   [STAGES];
  logic [BUS_WIDTH-1:0] r_sum [STAGES];

  logic                 w_v        [STAGES];
  logic                 w_sub      [STAGES];
  logic                 w_c        [STAGES];
  logic                 w_cmsb     [STAGES];
  logic [BUS_WIDTH-1:0] w_a        [STAGES];
  logic [BUS_WIDTH-1:0] w_b        [STAGES];
  logic [BUS_WIDTH-1:0] w_sum_prev [STAGES];

  logic [BUS_WIDTH-1:0] w_final_sum;
  logic                 w_final_cout;
  logic                 w_final_ovf;
  logic [BUS_WIDTH-1:0] w_res;

  logic [BUS_WIDTH-1:0] r_out;
  logic                 r_cout;
  logic                 r_ovf;
  logic                 r_zero;

  assign w_adv    = !r_v[STAGES-1] || out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG_W-1:0]     w_seg_sum;
    logic                 w_seg_cout;
    logic [BUS_WIDTH-1:0] w_sum_new;

    if (k == 0) begin : g_head
      assign w_v[k]        = in_valid;
      assign w_a[k]        = in1;
      assign w_b[k]        = in2;
      assign w_sub[k]      = add_sub_b;
      assign w_c[k]        = cin;
      assign w_sum_prev[k] = '0;
    end else begin : g_body
      assign w_v[k]        = r_v[k-1];
      assign w_a[k]        = r_a[k-1];
      assign w_b[k]        = r_b[k-1];
      assign w_sub[k]      = r_sub[k-1];
      assign w_c[k]        = r_c[k-1];
      assign w_sum_prev[k] = r_sum[k-1];
    end

    add_segment #(.SEG_W(SEG_W)) u_seg (
      .i_a     (w_a[k][k*SEG_W +: SEG_W]),
      .i_b     (w_b[k][k*SEG_W +: SEG_W] ^ {SEG_W{w_sub[k]}}),
      .i_cin   (w_c[k]),
      .o_sum   (w_seg_sum),
      .o_cout  (w_seg_cout),
      .o_c_msb (w_cmsb[k])
    );

    // Segments above k are still zero in the partial sum, so OR merges the new slice.
    assign w_sum_new = w_sum_prev[k] | (BUS_WIDTH'(w_seg_sum) << (k*SEG_W));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v[k]   <= 1'b0;
        r_sub[k] <= 1'b0;
        r_c[k]   <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end else if (w_adv) begin
        r_v[k]   <= w_v[k];
        r_sub[k] <= w_sub[k];
        r_c[k]   <= w_seg_cout;
        r_a[k]   <= w_a[k];
        r_b[k]   <= w_b[k];
        r_sum[k] <= w_sum_new;
      end
    end

    if (k == STAGES - 1) begin : g_tail
      assign w_final_sum  = w_sum_new;
      assign w_final_cout = w_seg_cout;
    end
  end

  assign w_final_ovf = w_cmsb[STAGES-1] ^ w_final_cout;
  assign w_res = (SATURATE && w_final_ovf)
               ? (w_a[STAGES-1][BUS_WIDTH-1] ? SAT_NEG : SAT_POS)
               : w_final_sum;

  // Result flags only load on a real op so bubbles leave the reset values intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b1;
    end else if (w_adv && w_v[STAGES-1]) begin
      r_out  <= w_res;
      r_cout <= w_final_cout;
      r_ovf  <= w_final_ovf;
      r_zero <= (w_res == '0);
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign out       = r_out;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Randomised and directed bench for pipelined_add_sub over STAGES {1,2,4,8} x SATURATE {0,1}.
module tb_pipelined_add_sub;

  typedef struct packed {
    logic [31:0] out;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        in_valid  = 1'b0;
  logic        add_sub_b = 1'b0;
  logic        cin       = 1'b0;
  logic        out_ready = 1'b1;
  logic        chk_drain = 1'b0;
  logic [31:0] in1       = '0;
  logic [31:0] in2       = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic c, input bit sat);
    res_t        r;
    logic [31:0] bb;
    logic [63:0] u;
    longint      s;
    bb     = sub ? ~b : b;
    u      = 64'(a) + 64'(bb) + 64'(c);
    s      = longint'($signed(a)) + longint'($signed(bb)) + longint'(c);
    r.cout = u[32];
    r.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    r.out  = u[31:0];
    if (sat && r.ovf) r.out = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    r.zero = (r.out == 32'h0);
    return r;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 8; g++) begin : g_cfg
    localparam int unsigned ST  = 1 << (g % 4);
    localparam bit          SAT = (g >= 4);

    logic        w_in_ready, w_out_valid, w_cout, w_ovf, w_zero;
    logic [31:0] w_out;
    res_t        q[$];
    res_t        held, cur, req;
    bit          was_stalled = 1'b0;

    pipelined_add_sub #(.BUS_WIDTH(32), .STAGES(ST), .SATURATE(SAT)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (w_in_ready),
      .add_sub_b (add_sub_b),
      .cin       (cin),
      .in1       (in1),
      .in2       (in2),
      .out_valid (w_out_valid),
      .out_ready (out_ready),
      .out       (w_out),
      .cout      (w_cout),
      .ovf       (w_ovf),
      .zero      (w_zero)
    );

    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        was_stalled = 1'b0;
      end else begin
        cur = {w_out, w_cout, w_ovf, w_zero};
        checks++;
        if (w_in_ready !== (!w_out_valid || out_ready)) begin
          errors++;
          $display("FAIL cfg%0d in_ready actual=%b required=%b", g, w_in_ready, !w_out_valid || out_ready);
        end
        if (was_stalled) begin
          checks++;
          if (w_out_valid !== 1'b1 || cur !== held) begin
            errors++;
            $display("FAIL cfg%0d stall_hold actual=%b/%h required=1/%h", g, w_out_valid, cur, held);
          end
        end
        if (w_out_valid === 1'b1) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cfg%0d spurious_out actual=%h required=none", g, cur);
          end else if (out_ready) begin
            req = q.pop_front();
            checks++;
            if (cur !== req) begin
              errors++;
              $display("FAIL cfg%0d result actual=%h required=%h", g, cur, req);
            end
          end
        end
        was_stalled = (w_out_valid === 1'b1) && !out_ready;
        held        = cur;
        if (in_valid && w_in_ready) q.push_back(model(in1, in2, add_sub_b, cin, SAT));
      end
    end

    always @(posedge chk_drain) begin
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL cfg%0d drain_pending actual=%0d required=0", g, q.size());
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic c, output res_t r4, output res_t r4s, output int lat);
    in1 = a; in2 = b; add_sub_b = sub; cin = c; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!g_cfg[2].w_out_valid && lat < 20) begin
      step();
      lat++;
    end
    r4  = {g_cfg[2].w_out, g_cfg[2].w_cout, g_cfg[2].w_ovf, g_cfg[2].w_zero};
    r4s = {g_cfg[6].w_out, g_cfg[6].w_cout, g_cfg[6].w_ovf, g_cfg[6].w_zero};
    repeat (10) step();
  endtask

  task automatic pulse_drain();
    chk_drain = 1'b1;
    #1;
    chk_drain = 1'b0;
  endtask

  initial begin
    res_t r4, r4s;
    int   lat, sent, cyc, cnt;
    bit   acc, saw_not_ready;

    repeat (3) step();
    check("reset_out_valid", 64'(g_cfg[2].w_out_valid), 64'd0);
    check("reset_out",       64'(g_cfg[2].w_out),       64'd0);
    check("reset_cout",      64'(g_cfg[2].w_cout),      64'd0);
    check("reset_ovf",       64'(g_cfg[2].w_ovf),       64'd0);
    check("reset_zero",      64'(g_cfg[2].w_zero),      64'd1);
    rst = 1'b0;
    step();
    check("reset_in_ready", 64'(g_cfg[2].w_in_ready), 64'd1);

    run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, r4, r4s, lat);
    check("add_latency", 64'(lat),     64'd4);
    check("add_out",     64'(r4.out),  64'h0);
    check("add_cout",    64'(r4.cout), 64'd1);
    check("add_ovf",     64'(r4.ovf),  64'd0);
    check("add_zero",    64'(r4.zero), 64'd1);

    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, r4, r4s, lat);
    check("sub_out",      64'(r4.out),   64'h7FFF_FFFF);
    check("sub_ovf",      64'(r4.ovf),   64'd1);
    check("sub_cout",     64'(r4.cout),  64'd1);
    check("sub_zero",     64'(r4.zero),  64'd0);
    check("sub_sat_out",  64'(r4s.out),  64'h8000_0000);
    check("sub_sat_ovf",  64'(r4s.ovf),  64'd1);

    run_op(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, r4, r4s, lat);
    check("ripple_out",  64'(r4.out),  64'h0100_0000);
    check("ripple_cout", 64'(r4.cout), 64'd0);
    check("ripple_ovf",  64'(r4.ovf),  64'd0);

    // Backpressure: 8 ops into the 4-stage instance, out_ready low for 5 cycles mid-stream.
    sent = 0; cyc = 0; saw_not_ready = 1'b0;
    in1 = rnd32(); in2 = rnd32(); add_sub_b = $urandom_range(0, 1); cin = $urandom_range(0, 1);
    while (sent < 8 && cyc < 100) begin
      in_valid  = 1'b1;
      out_ready = !(cyc >= 3 && cyc < 8);
      #1;
      acc = g_cfg[2].w_in_ready;
      if (!acc) saw_not_ready = 1'b1;
      step();
      cyc++;
      if (acc) begin
        sent++;
        in1 = rnd32(); in2 = rnd32(); add_sub_b = $urandom_range(0, 1); cin = $urandom_range(0, 1);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_all_sent",      64'(sent),          64'd8);
    check("bp_in_ready_drop", 64'(saw_not_ready), 64'd1);
    repeat (20) step();
    pulse_drain();

    // Reset with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      in1 = rnd32(); in2 = rnd32(); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(g_cfg[2].w_out_valid), 64'd0);
    check("midrst_zero",      64'(g_cfg[2].w_zero),      64'd1);
    step();
    step();
    rst = 1'b0;
    cnt = 0;
    repeat (15) begin
      step();
      if (g_cfg[2].w_out_valid) cnt++;
    end
    check("midrst_no_stale", 64'(cnt), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in1       = rnd32();
      in2       = rnd32();
      add_sub_b = $urandom_range(0, 1);
      cin       = $urandom_range(0, 1);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();
    pulse_drain();
    #2;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
